// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: bubble encoding, immediate
// select encodings, control bundle width, control bit positions and EX occupancy states.
package id_ex_pipe_reg_pkg;

  localparam int          CTRL_W    = 12;
  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    IMM_SEXT5  = 2'd0,
    IMM_ZEXT5  = 2'd1,
    IMM_SEXT8  = 2'd2,
    IMM_SEXT11 = 2'd3
  } imm_sel_e;

  // Bit positions inside the decoded control bundle.
  localparam int CTRL_REG_WE  = 0;
  localparam int CTRL_MEM_RD  = 1;
  localparam int CTRL_MEM_WR  = 2;
  localparam int CTRL_ALU_SRC = 3;
  localparam int CTRL_BRANCH  = 4;
  localparam int CTRL_JUMP    = 5;
  localparam int CTRL_HALT    = 6;

  typedef enum logic {
    EX_EMPTY = 1'b0,
    EX_FULL  = 1'b1
  } ex_state_e;

endpackage

// File: rtl/id_ex_pipe_reg_imm_ext_sel.sv
// Combinational immediate builder: 5b sign/zero, 8b sign and 11b sign extension
// of the low instruction field, chosen by a 4:1 select.
module imm_ext_sel
  import id_ex_pipe_reg_pkg::*;
(
  input  logic [10:0] imm_field,
  input  logic [1:0]  sel,
  output logic [15:0] imm
);

  logic [15:0] sext5;
  logic [15:0] zext5;
  logic [15:0] sext8;
  logic [15:0] sext11;

  assign sext5  = {{11{imm_field[4]}},  imm_field[4:0]};
  assign zext5  = {11'd0,               imm_field[4:0]};
  assign sext8  = {{8{imm_field[7]}},   imm_field[7:0]};
  assign sext11 = {{5{imm_field[10]}},  imm_field[10:0]};

  // Each leg only reads its own field bits, so upper instruction bits cannot leak in.
  always_comb begin
    imm = sext5;
    case (imm_sel_e'(sel))
      IMM_SEXT5:  imm = sext5;
      IMM_ZEXT5:  imm = zext5;
      IMM_SEXT8:  imm = sext8;
      IMM_SEXT11: imm = sext11;
      default:    imm = sext5;
    endcase
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register with stall, flush and valid tracking.
// Optional macro ID_EX_PERF_EN adds a saturating bubble_cnt output.
module id_ex_pipe_reg #(
  parameter int          CTRL_W    = id_ex_pipe_reg_pkg::CTRL_W,
  parameter logic [15:0] NOP_INSTR = id_ex_pipe_reg_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [15:0]       id_instr,
  input  logic [15:0]       id_rd1_data,
  input  logic [15:0]       id_rd2_data,
  input  logic [15:0]       id_pc_inc,
  input  logic [1:0]        id_imm_sel,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [2:0]        id_wr_reg,
  output logic              ex_valid,
  output logic [15:0]       ex_instr,
  output logic [15:0]       ex_rd1,
  output logic [15:0]       ex_rd2,
  output logic [15:0]       ex_imm,
  output logic [15:0]       ex_pc_inc,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [2:0]        ex_wr_reg
`ifdef ID_EX_PERF_EN
  ,
  output logic [15:0]       bubble_cnt
`endif
);

  import id_ex_pipe_reg_pkg::*;

  logic [15:0] imm_next;
  ex_state_e   state_reg;
  ex_state_e   state_next;

  imm_ext_sel u_imm_ext_sel (
    .imm_field (id_instr[10:0]),
    .sel       (id_imm_sel),
    .imm       (imm_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EX_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = EX_EMPTY;
    end else if (!stall) begin
      state_next = id_valid ? EX_FULL : EX_EMPTY;
    end
  end

  assign ex_valid = (state_reg == EX_FULL);

  // Flush only clears the fields that could cause side effects; data may hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_instr  <= NOP_INSTR;
      ex_rd1    <= 16'h0000;
      ex_rd2    <= 16'h0000;
      ex_imm    <= 16'h0000;
      ex_pc_inc <= 16'h0000;
      ex_ctrl   <= '0;
      ex_wr_reg <= 3'd0;
    end else if (flush) begin
      ex_instr  <= NOP_INSTR;
      ex_ctrl   <= '0;
      ex_wr_reg <= 3'd0;
    end else if (!stall) begin
      ex_instr  <= id_valid ? id_instr : NOP_INSTR;
      ex_rd1    <= id_rd1_data;
      ex_rd2    <= id_rd2_data;
      ex_imm    <= imm_next;
      ex_pc_inc <= id_pc_inc;
      ex_ctrl   <= id_valid ? id_ctrl : '0;
      ex_wr_reg <= id_wr_reg;
    end
  end

`ifdef ID_EX_PERF_EN
  // flush | stall | !id_valid covers "load of an invalid instruction" as the residual case.
  logic bubble_evt;
  assign bubble_evt = flush | stall | ~id_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= 16'h0000;
    end else if (bubble_evt && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg; define ID_EX_PERF_EN to also exercise bubble_cnt.
module tb_id_ex_pipe_reg;

  localparam int          CW  = 12;
  localparam logic [15:0] NOP = 16'h0800;

  logic          clk = 1'b0;
  logic          rst, stall, flush, id_valid;
  logic [15:0]   id_instr, id_rd1_data, id_rd2_data, id_pc_inc;
  logic [1:0]    id_imm_sel;
  logic [CW-1:0] id_ctrl;
  logic [2:0]    id_wr_reg;
  logic          ex_valid;
  logic [15:0]   ex_instr, ex_rd1, ex_rd2, ex_imm, ex_pc_inc;
  logic [CW-1:0] ex_ctrl;
  logic [2:0]    ex_wr_reg;
`ifdef ID_EX_PERF_EN
  logic [15:0]   bubble_cnt;
`endif

  id_ex_pipe_reg dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_rd1_data (id_rd1_data),
    .id_rd2_data (id_rd2_data),
    .id_pc_inc   (id_pc_inc),
    .id_imm_sel  (id_imm_sel),
    .id_ctrl     (id_ctrl),
    .id_wr_reg   (id_wr_reg),
    .ex_valid    (ex_valid),
    .ex_instr    (ex_instr),
    .ex_rd1      (ex_rd1),
    .ex_rd2      (ex_rd2),
    .ex_imm      (ex_imm),
    .ex_pc_inc   (ex_pc_inc),
    .ex_ctrl     (ex_ctrl),
    .ex_wr_reg   (ex_wr_reg)
`ifdef ID_EX_PERF_EN
    ,
    .bubble_cnt  (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic [15:0]   instr;
    logic [15:0]   rd1;
    logic [15:0]   rd2;
    logic [15:0]   imm;
    logic [15:0]   pc;
    logic [CW-1:0] ctrl;
    logic [2:0]    wr;
  } ex_t;

  ex_t model;
  ex_t exp_q[$];
  ex_t e;
  int  checks = 0;
  int  errors = 0;
  int  txn = 0;

  function automatic logic [15:0] ref_imm(input logic [15:0] ins, input logic [1:0] sel);
    logic signed [15:0] s;
    case (sel)
      2'd0:    s = 16'($signed(ins[4:0]));
      2'd1:    s = 16'(ins[4:0]);
      2'd2:    s = 16'($signed(ins[7:0]));
      default: s = 16'($signed(ins[10:0]));
    endcase
    return s;
  endfunction

  function automatic ex_t observed();
    return {ex_valid, ex_instr, ex_rd1, ex_rd2, ex_imm, ex_pc_inc, ex_ctrl, ex_wr_reg};
  endfunction

  task automatic randomize_id();
    id_instr    = 16'($urandom);
    id_rd1_data = 16'($urandom);
    id_rd2_data = 16'($urandom);
    id_pc_inc   = 16'($urandom);
    id_imm_sel  = 2'($urandom);
    id_ctrl     = CW'($urandom);
    id_wr_reg   = 3'($urandom);
    id_valid    = 1'($urandom);
  endtask

  // Push the expected EX contents for the current inputs, then clock once.
  task automatic drive();
    ex_t n;
    n = model;
    if (rst) begin
      n = '0;
      n.instr = NOP;
    end else if (flush) begin
      n.valid = 1'b0;
      n.ctrl  = '0;
      n.instr = NOP;
      n.wr    = 3'd0;
    end else if (!stall) begin
      n.valid = id_valid;
      n.instr = id_valid ? id_instr : NOP;
      n.rd1   = id_rd1_data;
      n.rd2   = id_rd2_data;
      n.imm   = ref_imm(id_instr, id_imm_sel);
      n.pc    = id_pc_inc;
      n.ctrl  = id_valid ? id_ctrl : '0;
      n.wr    = id_wr_reg;
    end
    exp_q.push_back(n);
    model = n;
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d rst=%b flush=%b stall=%b -> valid=%b instr=%h rd1=%h rd2=%h imm=%h pc=%h ctrl=%h wr=%0d",
             txn, rst, flush, stall, ex_valid, ex_instr, ex_rd1, ex_rd2, ex_imm, ex_pc_inc, ex_ctrl, ex_wr_reg);
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      randomize_id();
      drive();
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL reset_state got %h want %h", observed(), e);
      end
    end
    checks++;
    if (ex_instr !== 16'h0800) begin
      errors++;
      $display("FAIL reset_nop got %h want 0800", ex_instr);
    end
    rst = 1'b0;
  endtask

  task automatic test_immediates();
    logic [15:0] instrs [5] = '{16'h0015, 16'h0015, 16'h0080, 16'h0400, 16'h03FF};
    logic [1:0]  sels   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [15:0] imms   [5] = '{16'hFFF5, 16'h0015, 16'hFF80, 16'hFC00, 16'h03FF};
    for (int i = 0; i < 5; i++) begin
      randomize_id();
      id_valid = 1'b1; id_instr = instrs[i]; id_imm_sel = sels[i];
      drive();
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e || ex_imm !== imms[i]) begin
        errors++;
        $display("FAIL imm_%0d got imm %h want %h (full got %h want %h)", i, ex_imm, imms[i], observed(), e);
      end
    end
  endtask

  task automatic test_stall();
    randomize_id();
    id_valid = 1'b1; id_rd1_data = 16'hABCD;
    drive();
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("FAIL stall_load got %h want %h", observed(), e);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_id();
      id_rd1_data = 16'h1234;
      drive();
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e || ex_rd1 !== 16'hABCD) begin
        errors++;
        $display("FAIL stall_hold_%0d got rd1 %h want abcd (full got %h want %h)", i, ex_rd1, observed(), e);
      end
    end
    stall = 1'b0;
    drive();
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e || ex_rd1 !== 16'h1234) begin
      errors++;
      $display("FAIL stall_release got rd1 %h want 1234", ex_rd1);
    end
  endtask

  task automatic test_flush_vs_stall();
    randomize_id();
    id_valid = 1'b1; id_ctrl = 12'hA5C; id_wr_reg = 3'd5;
    drive();
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_preload got %h want %h", observed(), e);
    end
    flush = 1'b1; stall = 1'b1;
    randomize_id();
    drive();
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e || ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_instr !== 16'h0800) begin
      errors++;
      $display("FAIL flush_over_stall got valid %b ctrl %h instr %h want 0 000 0800", ex_valid, ex_ctrl, ex_instr);
    end
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_invalid_input();
    randomize_id();
    id_valid = 1'b0; id_ctrl = '1;
    drive();
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e || ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_instr !== NOP) begin
      errors++;
      $display("FAIL invalid_bubble got valid %b ctrl %h instr %h want 0 000 0800", ex_valid, ex_ctrl, ex_instr);
    end
  endtask

  task automatic test_reset_mid_stall();
    randomize_id();
    id_valid = 1'b1;
    drive();
    void'(exp_q.pop_front());
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    randomize_id();
    drive();
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("FAIL reset_mid_stall got %h want %h", observed(), e);
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    randomize_id();
    id_valid = 1'b1;
    drive();
    e = exp_q.pop_front();
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("FAIL reset_resume got %h want %h", observed(), e);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      randomize_id();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      drive();
      e = exp_q.pop_front();
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL back_to_back_%0d got %h want %h", i, observed(), e);
      end
    end
    stall = 1'b0; flush = 1'b0;
  endtask

`ifdef ID_EX_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    drive();
    void'(exp_q.pop_front());
    rst = 1'b0; stall = 1'b1;
    repeat (16'hFFFE) @(posedge clk);
    #1;
    checks++;
    if (bubble_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL perf_prefill got %h want fffe", bubble_cnt);
    end
    stall = 1'b0; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive();
      void'(exp_q.pop_front());
      checks++;
      if (bubble_cnt !== 16'hFFFF) begin
        errors++;
        $display("FAIL perf_saturate_%0d got %h want ffff", i, bubble_cnt);
      end
    end
    flush = 1'b0; rst = 1'b1;
    drive();
    void'(exp_q.pop_front());
    checks++;
    if (bubble_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL perf_reset got %h want 0000", bubble_cnt);
    end
    rst = 1'b0;
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model = '0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    randomize_id();
    @(posedge clk);
    #1;
    test_reset();
    test_immediates();
    test_stall();
    test_flush_vs_stall();
    test_invalid_input();
    test_reset_mid_stall();
    test_back_to_back();
`ifdef ID_EX_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Decode-to-execute pipeline register of the 16-bit pipelined processor; sits directly downstream of the decode-stage immediate sign/zero extenders.
- Selects the immediate form (5b/8b/11b sign-extend, 5b zero-extend) from the decoded instruction, then registers it with register-file read data, PC+2 and control bits into the EX stage.
- Supports stall (hold), flush (bubble insert) and a valid bit.

Parameters:
- CTRL_W, 12, width of the decoded control bundle carried to EX.
- NOP_INSTR, 16'h0800, instruction word presented on a bubble.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold all EX-side registers this cycle.
- flush  input  1  replace next EX contents with a bubble.
- id_valid  input  1  ID stage holds a real instruction.
- id_instr  input  16  decoded instruction word.
- id_rd1_data  input  16  register file read port 1.
- id_rd2_data  input  16  register file read port 2.
- id_pc_inc  input  16  PC+2 of the instruction.
- id_imm_sel  input  2  immediate form: 0=sext instr[4:0], 1=zext instr[4:0], 2=sext instr[7:0], 3=sext instr[10:0].
- id_ctrl  input  CTRL_W  control bundle from decoder.
- id_wr_reg  input  3  destination register index.
- ex_valid  output  1  EX stage holds a real instruction.
- ex_instr  output  16  registered instruction.
- ex_rd1  output  16  registered read data 1.
- ex_rd2  output  16  registered read data 2.
- ex_imm  output  16  registered extended immediate.
- ex_pc_inc  output  16  registered PC+2.
- ex_ctrl  output  CTRL_W  registered control; all-zero on bubble.
- ex_wr_reg  output  3  registered destination register.

Behaviour:
- Reset: ex_valid=0, ex_instr=NOP_INSTR, ex_ctrl=0, ex_wr_reg=0, ex_rd1/ex_rd2/ex_imm/ex_pc_inc=16'h0000.
- Priority per posedge: rst > flush > stall > load.
- Load (no rst, no flush, no stall): all ex_* take id_* values next cycle; ex_valid=id_valid; latency 1 cycle.
- If id_valid=0 on load: data fields captured but ex_ctrl forced to 0 and ex_instr=NOP_INSTR (bubble; no architectural side effects).
- Stall: every ex_* register holds its value, including ex_valid.
- Flush: bubble loaded (ex_valid=0, ex_ctrl=0, ex_instr=NOP_INSTR, ex_wr_reg=0); data fields may hold. Flush overrides a simultaneous stall.
- Immediate extension is combinational before the register. Widths are exact: sext replicates bit 4, 7 or 10 into all upper bits to 16b; zext fills zeros. Unknown X never propagates from unused instr bits.
- Reset mid-stall or mid-flush: reset values win that cycle; normal operation resumes the next cycle.
- State model (ex_valid): EMPTY(0) -> FULL(1) on load with id_valid=1; FULL -> EMPTY on flush or on load with id_valid=0; either -> self on stall.

Optional Feature:
- Macro ID_EX_PERF_EN.
- Defined: adds output bubble_cnt[15:0], a saturating count (stops at 16'hFFFF) of cycles where flush=1 or stall=1, or a load captures id_valid=0. Resets to 0 on rst.
- Undefined: port and counter are absent; no other behaviour changes.

Decomposition:
- Shared package/include: NOP_INSTR, IMM_SEXT5/IMM_ZEXT5/IMM_SEXT8/IMM_SEXT11 select encodings, CTRL_W, control-bit index constants.
- One sub-module: imm_ext_sel, combinational, 16-bit out. It instantiates the existing 5b sign extender plus 8b/11b extenders and a 4:1 mux. Register logic stays in the top.

Test Plan:
- Reset: assert rst 2 cycles with id_* random -> all ex_* at reset values; ex_instr=16'h0800.
- Immediates: id_instr=16'h0015, sel=0 -> ex_imm=16'hFFF5; sel=1 -> 16'h0015; id_instr=16'h0080, sel=2 -> 16'hFF80; id_instr=16'h0400, sel=3 -> 16'hFC00; id_instr=16'h03FF, sel=3 -> 16'h03FF.
- Stall: load rd1=16'hABCD, then stall 3 cycles while rd1=16'h1234 -> ex_rd1 stays 16'hABCD; unstall -> 16'h1234 after 1 cycle.
- Flush vs stall: ex_valid=1, assert flush and stall together -> next cycle ex_valid=0, ex_ctrl=0, ex_instr=16'h0800.
- Invalid input: id_valid=0, id_ctrl all-ones -> ex_valid=0, ex_ctrl=0.
- ID_EX_PERF_EN: 0xFFFE prior bubbles then 3 flush cycles -> bubble_cnt=16'hFFFF (saturated); rst -> 0.
